// File: rtl/pseudo_rand_check.sv
// pseudo_rand_check
//   Self-synchronizing checker for a Galois-LFSR pseudo-random stream.
//   Seeds its predictor from the incoming data (HUNT), confirms lock over
//   LOCK_CNT matching words (VERIFY), then flywheels the predictor and counts
//   mismatches (LOCKED). LOSS_CNT consecutive mismatches drop back to HUNT.
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   in_valid        : in_data carries a stream word this cycle
//   in_data[WIDTH]  : received word
//   clear_cnt       : synchronous clear of err_cnt / word_cnt
//   locked          : checker is in LOCKED
//   err_pulse       : previous accepted word mismatched while LOCKED
//   err_cnt[CNT_W]  : mismatches while LOCKED (saturating)
//   word_cnt[CNT_W] : words checked while LOCKED (saturating)
module pseudo_rand_check #(
  parameter int WIDTH    = 64,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  generate
    if (!(WIDTH == 64 || WIDTH == 128 || WIDTH == 257)) begin : g_bad_width
      $error("pseudo_rand_check: WIDTH must be 64, 128 or 257");
    end
    if (LOCK_CNT < 1 || LOSS_CNT < 1) begin : g_bad_cnt
      $error("pseudo_rand_check: LOCK_CNT and LOSS_CNT must be >= 1");
    end
  endgenerate

  localparam logic [7:0] POLY_LO = (WIDTH == 64)  ? 8'b00011011 :
                                   (WIDTH == 128) ? 8'b10000111 : 8'b11000101;
  localparam logic [WIDTH-1:0] POLY = {{(WIDTH-8){1'b0}}, POLY_LO};

  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & POLY);
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [RUN_W-1:0]   run_inc;
  logic               match, nonzero;

  assign run_inc = run_q + 1'b1;
  assign match   = (in_data == exp_q);
  assign nonzero = (in_data != '0);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // An all-zero word is the LFSR lockup state and cannot seed.
          if (nonzero) begin
            exp_d   = lfsr_next(in_data);
            run_d   = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            exp_d = lfsr_next(in_data);
            if (run_inc == RUN_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else if (nonzero) begin
            exp_d = lfsr_next(in_data);   // re-seed from the new word
            run_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: predict from our own state so one bad word does not
          // corrupt the following predictions.
          exp_d = lfsr_next(exp_q);
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
          if (match) begin
            run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (run_inc == RUN_W'(LOSS_CNT)) begin
              state_d = HUNT;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear wins over a same-cycle increment; err_pulse is unaffected.
    if (clear_cnt) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      run_q       <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;

endmodule
